// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Control FSM for the multicycle RV32I datapath (lw, sw, R-type, I-type ALU,
//   beq, jal). It decodes op/funct3/funct7b5 and drives datapath enables, mux
//   selects and the ALU control code. It uses the ALU zero flag for branches
//   and stalls on memory through a mem_ready handshake.
//
//   Optional feature: define MC_CTRL_BNE_EN to accept bne. bne shares the
//   branch state and qualifies pcwrite with ~zero.
//
// Parameters
//   MEM_HANDSHAKE   1: FETCH/MEMREAD/MEMWRITE wait for mem_ready
//                   0: mem_ready is ignored (single-cycle memory)
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   op/funct3/funct7b5  instruction fields from the instruction register
//   zero            ALU zero flag
//   mem_ready       memory access completes this cycle
//   pcwrite, adrsrc, memwrite, irwrite, regwrite   datapath enables/selects
//   resultsrc, alusrca, alusrcb, immsrc            datapath mux selects
//   alucontrol      ALU operation (constants::ALU_*)
//   illegal_instr   one-cycle pulse on an undecodable instruction
// -----------------------------------------------------------------------------
package constants;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
endpackage

module multicycle_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_instr
);
    import constants::*;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
    } state_t;

    state_t state_q, state_d;

    logic       mem_rdy;
    logic       br_is_bne, br_legal;
    logic [2:0] alu_op;
    logic       alu_legal;
    logic       pcwrite_c, memwrite_c, irwrite_c, regwrite_c, illegal_c;

    assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

`ifdef MC_CTRL_BNE_EN
    assign br_is_bne = (funct3 == 3'b001);
`else
    assign br_is_bne = 1'b0;
`endif
    assign br_legal = (funct3 == 3'b000) || br_is_bne;

    // ALU operation for the execute states; unsupported funct3 is flagged.
    always_comb begin
        alu_op    = ALU_ADD;
        alu_legal = 1'b1;
        case (funct3)
            3'b000:  alu_op = ((op == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BR:   immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pcwrite_c  = 1'b0;
        adrsrc     = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        illegal_c  = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        alucontrol = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite_c = mem_rdy;
                pcwrite_c = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures the branch target (oldPC + imm).
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BR: begin
                        if (br_legal) begin
                            state_d = S_BEQ;
                        end else begin
                            illegal_c = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite_c = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alusrca    = 2'b10;
                alusrcb    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alucontrol = alu_op;
                if (alu_legal) begin
                    state_d = S_ALUWB;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alusrca    = 2'b10;
                alucontrol = ALU_SUB;
                pcwrite_c  = br_is_bne ? ~zero : zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // ALU computes oldPC + 4 for rd while PC takes the jump target.
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                pcwrite_c = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables and strobes are forced low for as long as reset is asserted,
    // including FETCH's mem_ready-driven irwrite/pcwrite.
    assign pcwrite       = rst_n & pcwrite_c;
    assign memwrite      = rst_n & memwrite_c;
    assign irwrite       = rst_n & irwrite_c;
    assign regwrite      = rst_n & regwrite_c;
    assign illegal_instr = rst_n & illegal_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end
endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
module tb_multicycle_controller;
    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;
    localparam logic [2:0] A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011;
    localparam logic [2:0] A_SLT = 3'b101;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Observation vector: {pcwrite, adrsrc, memwrite, irwrite, regwrite,
    //                      illegal_instr, resultsrc, alusrca, alusrcb, alucontrol}
    localparam logic [14:0] M_EN  = 15'h5E00;
    localparam logic [14:0] M_ADR = 15'h2000;
    localparam logic [14:0] M_RS  = 15'h0180;
    localparam logic [14:0] M_SA  = 15'h0060;
    localparam logic [14:0] M_SB  = 15'h0018;
    localparam logic [14:0] M_ALU = 15'h0007;
    localparam logic [14:0] M_ALL = 15'h7FFF;
    localparam logic [14:0] FETCH_IDLE = {6'b000000, 2'b10, 2'b00, 2'b10, A_ADD};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal_instr;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .immsrc(immsrc), .alucontrol(alucontrol), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [14:0] v;
        logic [14:0] m;
        bit          waitm;
    } step_t;

    step_t plan[$];

    function automatic logic [14:0] obs();
        return {pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal_instr,
                resultsrc, alusrca, alusrcb, alucontrol};
    endfunction

    // en = {pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal}
    function automatic step_t mk(string nm, bit w, logic [5:0] en, logic [1:0] rs,
                                 logic [1:0] sa, logic [1:0] sb, logic [2:0] alu,
                                 logic [14:0] cm);
        step_t s;
        s.name  = nm;
        s.waitm = w;
        s.v     = {en, rs, sa, sb, alu};
        s.m     = M_EN | cm;
        return s;
    endfunction

    // Cycle-by-cycle expectation for one instruction, from the instruction's
    // class: which steps it passes through and what each step drives.
    function automatic void build_plan(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
        bit         is_bne;
        bit         decode_ok;
        bit         alu_ok;
        logic [2:0] alu;
        plan.delete();
        plan.push_back(mk("FETCH", 1'b1, 6'b100100, 2'b10, 2'b00, 2'b10, A_ADD,
                          M_ADR | M_RS | M_SA | M_SB | M_ALU));
        is_bne = 1'b0;
`ifdef MC_CTRL_BNE_EN
        is_bne = (o == OP_BR) && (f3 == 3'b001);
`endif
        decode_ok = (o inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL}) ||
                    ((o == OP_BR) && ((f3 == 3'b000) || is_bne));
        plan.push_back(mk("DECODE", 1'b0, decode_ok ? 6'b000000 : 6'b000001,
                          2'b00, 2'b01, 2'b01, A_ADD, M_SA | M_SB | M_ALU));
        if (!decode_ok) return;
        if (o == OP_LW || o == OP_SW)
            plan.push_back(mk("MEMADR", 1'b0, 6'b000000, 2'b00, 2'b10, 2'b01, A_ADD,
                              M_SA | M_SB | M_ALU));
        if (o == OP_LW) begin
            plan.push_back(mk("MEMREAD", 1'b1, 6'b010000, 2'b00, 2'b00, 2'b00, A_ADD, M_ADR | M_RS));
            plan.push_back(mk("MEMWB", 1'b0, 6'b000010, 2'b01, 2'b00, 2'b00, A_ADD, M_RS));
        end else if (o == OP_SW) begin
            plan.push_back(mk("MEMWRITE", 1'b1, 6'b011000, 2'b00, 2'b00, 2'b00, A_ADD, M_ADR | M_RS));
        end else if (o == OP_R || o == OP_I) begin
            alu_ok = 1'b1;
            alu    = A_ADD;
            case (f3)
                3'b000:  alu = (o == OP_R && f7) ? A_SUB : A_ADD;
                3'b010:  alu = A_SLT;
                3'b110:  alu = A_OR;
                3'b111:  alu = A_AND;
                default: alu_ok = 1'b0;
            endcase
            if (alu_ok) begin
                plan.push_back(mk("EXECUTE", 1'b0, 6'b000000, 2'b00, 2'b10,
                                  (o == OP_R) ? 2'b00 : 2'b01, alu, M_SA | M_SB | M_ALU));
                plan.push_back(mk("ALUWB", 1'b0, 6'b000010, 2'b00, 2'b00, 2'b00, A_ADD, M_RS));
            end else begin
                plan.push_back(mk("EXECUTE", 1'b0, 6'b000001, 2'b00, 2'b10,
                                  (o == OP_R) ? 2'b00 : 2'b01, A_ADD, M_SA | M_SB));
            end
        end else if (o == OP_BR) begin
            plan.push_back(mk("BEQ", 1'b0, {(is_bne ? ~z : z), 5'b00000}, 2'b00, 2'b10, 2'b00,
                              A_SUB, M_RS | M_SA | M_SB | M_ALU));
        end else begin
            plan.push_back(mk("JAL", 1'b0, 6'b100000, 2'b00, 2'b01, 2'b10, A_ADD,
                              M_RS | M_SA | M_SB | M_ALU));
            plan.push_back(mk("ALUWB", 1'b0, 6'b000010, 2'b00, 2'b00, 2'b00, A_ADD, M_RS));
        end
    endfunction

    // Runs one instruction from FETCH, holding mem_ready low for 'stall'
    // cycles in each memory-wait step, then checks the controller is idling
    // in FETCH afterwards. Entered and left at #1 after a rising edge.
    task automatic exec_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input logic z, input int stall,
                              output int cycles, output int n_ir, output int n_rw);
        int          waited;
        logic        rdy;
        logic [14:0] e;
        logic [14:0] g;
        logic [1:0]  imm_exp;
        build_plan(o, f3, f7, z);
        op = o; funct3 = f3; funct7b5 = f7;
        cycles = 0; n_ir = 0; n_rw = 0;
        foreach (plan[i]) begin
            waited = 0;
            forever begin
                if (plan[i].waitm) rdy = (waited >= stall) ? 1'b1 : 1'b0;
                else               rdy = 1'($urandom_range(0, 1));
                mem_ready = rdy;
                zero = (plan[i].name == "BEQ") ? z : 1'($urandom_range(0, 1));
                @(negedge clk);
                e = plan[i].v;
                if (plan[i].name == "FETCH" && !rdy) begin
                    e[14] = 1'b0;
                    e[11] = 1'b0;
                end
                g = obs();
                n_checks++;
                if ((g & plan[i].m) !== (e & plan[i].m)) begin
                    n_fail++;
                    $display("FAIL %s op=%b f3=%b cyc=%0d: got %b expected %b mask %b",
                             plan[i].name, o, f3, cycles, g, e, plan[i].m);
                end
                if (plan[i].name == "DECODE" && o inside {OP_LW, OP_I, OP_SW, OP_BR, OP_JAL}) begin
                    imm_exp = (o == OP_SW) ? 2'b01 : (o == OP_BR) ? 2'b10 :
                              (o == OP_JAL) ? 2'b11 : 2'b00;
                    n_checks++;
                    if (immsrc !== imm_exp) begin
                        n_fail++;
                        $display("FAIL immsrc op=%b: got %b expected %b", o, immsrc, imm_exp);
                    end
                end
                cycles++;
                n_ir += int'(irwrite);
                n_rw += int'(regwrite);
                @(posedge clk); #1;
                if (!plan[i].waitm || rdy) break;
                waited++;
            end
        end
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs() !== FETCH_IDLE) begin
            n_fail++;
            $display("FAIL back_to_fetch op=%b f3=%b: got %b expected %b", o, f3, obs(), FETCH_IDLE);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [14:0] g;
        rst_n = 1'b0; mem_ready = 1'b1; op = OP_SW; funct3 = 3'b010; zero = 1'b1;
        #3;
        g = obs();
        n_checks++;
        if (g !== FETCH_IDLE) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", g, FETCH_IDLE);
        end
        repeat (2) @(posedge clk);
        #1;
        g = obs();
        n_checks++;
        if (g !== FETCH_IDLE) begin
            n_fail++;
            $display("FAIL reset_held_over_clocks: got %b expected %b", g, FETCH_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({irwrite, pcwrite} !== 2'b11) begin
            n_fail++;
            $display("FAIL release_fetch irwrite/pcwrite: got %b expected 11", {irwrite, pcwrite});
        end
        // Walk the sw into MEMWRITE, stall it there, then reset mid-access.
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if ({memwrite, adrsrc} !== 2'b11) begin
            n_fail++;
            $display("FAIL memwrite_stalled: got %b expected 11", {memwrite, adrsrc});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({memwrite, regwrite, pcwrite, irwrite} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_memwrite_reset strobes: got %b expected 0000",
                     {memwrite, regwrite, pcwrite, irwrite});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs() !== FETCH_IDLE) begin
            n_fail++;
            $display("FAIL after_release_fetch: got %b expected %b", obs(), FETCH_IDLE);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs() !== FETCH_IDLE) begin
            n_fail++;
            $display("FAIL no_partial_strobe: got %b expected %b", obs(), FETCH_IDLE);
        end
    endtask

    task automatic test_lw_stall();
        int c, ni, nr;
        exec_instr(OP_LW, 3'b010, 1'b0, 1'b0, 2, c, ni, nr);
        n_checks++;
        if (c !== 9) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d expected 9", c); end
        n_checks++;
        if (ni !== 1) begin n_fail++; $display("FAIL lw_irwrite_count: got %0d expected 1", ni); end
        n_checks++;
        if (nr !== 1) begin n_fail++; $display("FAIL lw_regwrite_count: got %0d expected 1", nr); end
        exec_instr(OP_LW, 3'b010, 1'b1, 1'b0, 0, c, ni, nr);
        n_checks++;
        if (c !== 5) begin n_fail++; $display("FAIL lw_cycles: got %0d expected 5", c); end
        exec_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, c, ni, nr);
        n_checks++;
        if (c !== 4) begin n_fail++; $display("FAIL sw_cycles: got %0d expected 4", c); end
        exec_instr(OP_SW, 3'b010, 1'b0, 1'b0, 3, c, ni, nr);
        n_checks++;
        if (c !== 10) begin n_fail++; $display("FAIL sw_stall_cycles: got %0d expected 10", c); end
    endtask

    task automatic test_alu();
        int c, ni, nr;
        logic [2:0] f3s[4] = '{3'b000, 3'b010, 3'b110, 3'b111};
        exec_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, c, ni, nr);
        n_checks++;
        if (c !== 4) begin n_fail++; $display("FAIL sub_cycles: got %0d expected 4", c); end
        exec_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, c, ni, nr);
        n_checks++;
        if (nr !== 1) begin n_fail++; $display("FAIL addi_regwrite: got %0d expected 1", nr); end
        foreach (f3s[k]) begin
            exec_instr(OP_R, f3s[k], 1'($urandom_range(0, 1)), 1'b0, 0, c, ni, nr);
            exec_instr(OP_I, f3s[k], 1'($urandom_range(0, 1)), 1'b0, 0, c, ni, nr);
            n_checks++;
            if (c !== 4) begin n_fail++; $display("FAIL itype_cycles f3=%b: got %0d expected 4", f3s[k], c); end
        end
    endtask

    task automatic test_branch_jal();
        int c, ni, nr;
        exec_instr(OP_BR, 3'b000, 1'b0, 1'b1, 0, c, ni, nr);
        n_checks++;
        if (c !== 3) begin n_fail++; $display("FAIL beq_taken_cycles: got %0d expected 3", c); end
        exec_instr(OP_BR, 3'b000, 1'b0, 1'b0, 0, c, ni, nr);
        n_checks++;
        if (c !== 3) begin n_fail++; $display("FAIL beq_not_taken_cycles: got %0d expected 3", c); end
        exec_instr(OP_JAL, 3'b101, 1'b1, 1'b0, 0, c, ni, nr);
        n_checks++;
        if (c !== 4 || nr !== 1) begin
            n_fail++;
            $display("FAIL jal_cycles_regwrite: got %0d/%0d expected 4/1", c, nr);
        end
    endtask

    task automatic test_illegal();
        int c, ni, nr;
        exec_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, c, ni, nr);
        n_checks++;
        if (c !== 2) begin n_fail++; $display("FAIL illegal_op_cycles: got %0d expected 2", c); end
        exec_instr(OP_R, 3'b001, 1'b0, 1'b0, 0, c, ni, nr);
        n_checks++;
        if (c !== 3 || nr !== 0) begin
            n_fail++;
            $display("FAIL illegal_rtype: got %0d cycles %0d regwrites expected 3/0", c, nr);
        end
        exec_instr(OP_I, 3'b101, 1'b0, 1'b0, 0, c, ni, nr);
        exec_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 0, c, ni, nr);
        exec_instr(OP_BR, 3'b001, 1'b0, 1'b1, 0, c, ni, nr);
        exec_instr(OP_BR, 3'b001, 1'b0, 1'b0, 0, c, ni, nr);
        exec_instr(OP_BR, 3'b100, 1'b0, 1'b1, 0, c, ni, nr);
    endtask

    task automatic test_back_to_back();
        int c, ni, nr;
        logic [6:0] pool[8] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, 7'b0110111, 7'b0000000};
        for (int n = 0; n < 40; n++) begin
            exec_instr(pool[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), c, ni, nr);
        end
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_alu();
        test_branch_jal();
        test_illegal();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
